// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped UART transmitter on the core store bus.
// Each contiguous byte store to TX_ADDR is captured once into a FIFO.
// The FIFO drains LSB first as 8N1 frames on tx_o.
// Optional build macro IO_UART_TX_PARITY_EN adds an even-parity bit
// between the data and stop bits, giving an 8E1 frame.
module io_uart_tx #(
  parameter logic [15:0] TX_ADDR      = 16'h0004,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [15:0]                       addr_i,
  input  logic [15:0]                       data_i,
  input  logic [2:0]                        signals_i,
  output logic                              tx_o,
  output logic                              busy_o,
  output logic                              full_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
  output logic                              overflow_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]  FULL_CNT    = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef IO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Even parity of a data byte: the XOR of all eight bits.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  // Store-bus snoop and FIFO bookkeeping.
  logic              hit;
  logic              hit_q;
  logic              push;
  logic              push_ok;
  logic              pop;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [7:0]        mem [FIFO_DEPTH];

  // Serialiser.
  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic              baud_done;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_q;
`ifdef IO_UART_TX_PARITY_EN
  logic              parity_q;
`endif

  // Upper data byte and the reg_write/branch flags carry nothing for us.
  logic              unused_bits;
  assign unused_bits = ^{data_i[15:8], signals_i[1:0]};

  // A store may be held for several cycles; only its first cycle pushes.
  assign hit  = signals_i[2] && (addr_i == TX_ADDR);
  assign push = hit && !hit_q;

  // The idle serialiser takes the head whenever something is queued. Count
  // is registered, so a push landing in an empty FIFO is popped one cycle
  // later, never in the same cycle.
  assign pop = (state == S_IDLE) && (count_o != '0);

  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign push_ok   = push && ((count_o != FULL_CNT) || pop);
  assign full_o    = (count_o == FULL_CNT);
  assign baud_done = (baud_cnt == '0);

  // Edge detector, FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      hit_q <= hit;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !push_ok) begin
        overflow_o <= 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count_o <= count_o + CNT_W'(1);
        2'b01:   count_o <= count_o - CNT_W'(1);
        default: count_o <= count_o;
      endcase
    end
  end

  // FIFO storage; contents are meaningless until the pointers say otherwise.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_i[7:0];
    end
  end

  // Shift register loaded on pop and shifted right as each data bit ends.
  always_ff @(posedge clk_i) begin
    if (pop) begin
      shift_q <= mem[rd_ptr];
`ifdef IO_UART_TX_PARITY_EN
      parity_q <= even_parity(mem[rd_ptr]);
`endif
    end else if ((state == S_DATA) && baud_done) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  // Frame sequencer; tx_o and busy_o are registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      tx_o     <= 1'b1;
      busy_o   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx_o <= 1'b1;
          if (count_o != '0) begin
            state    <= S_START;
            busy_o   <= 1'b1;
            tx_o     <= 1'b0;
            baud_cnt <= BAUD_RELOAD;
          end
        end

        S_START: begin
          if (baud_done) begin
            state    <= S_DATA;
            tx_o     <= shift_q[0];
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= '0;
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
              state <= S_PARITY;
              tx_o  <= parity_q;
`else
              state <= S_STOP;
              tx_o  <= 1'b1;
`endif
            end else begin
              // shift_q moves right on this same edge, so bit 1 is next.
              bit_idx <= bit_idx + 3'd1;
              tx_o    <= shift_q[1];
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

`ifdef IO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_done) begin
            state    <= S_STOP;
            tx_o     <= 1'b1;
            baud_cnt <= BAUD_RELOAD;
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end
`endif

        S_STOP: begin
          tx_o <= 1'b1;
          if (baud_done) begin
            // Back to IDLE for one cycle; that cycle pops the next byte.
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

        default: begin
          state  <= S_IDLE;
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: self-checking bench for io_uart_tx.
// A queue-and-waveform model of the transmitter is compared against the fast
// instance (CLKS_PER_BIT=4) every cycle; directed checks with hand-computed
// literals pin the model and exercise a default-rate (868) instance.
module tb_io_uart_tx;

  localparam int CPB      = 4;
  localparam int DEPTH    = 16;
  localparam int SLOW_CPB = 868;
`ifdef IO_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_LEN = FRAME_BITS * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [15:0] addr_i    = '0;
  logic [15:0] data_i    = '0;
  logic [2:0]  signals_i = '0;
  logic        tx_o, busy_o, full_o, overflow_o;
  logic [4:0]  count_o;

  logic [15:0] addr2 = '0;
  logic [15:0] data2 = '0;
  logic [2:0]  sig2  = '0;
  logic        tx2, busy2, full2, ovf2;
  logic [4:0]  count2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  io_uart_tx #(.TX_ADDR(16'h0004), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr_i), .data_i(data_i), .signals_i(signals_i),
    .tx_o(tx_o), .busy_o(busy_o), .full_o(full_o), .count_o(count_o), .overflow_o(overflow_o)
  );

  io_uart_tx #(.TX_ADDR(16'h0004), .CLKS_PER_BIT(SLOW_CPB), .FIFO_DEPTH(DEPTH)) dut_slow (
    .clk_i(clk), .rst_i(rst), .addr_i(addr2), .data_i(data2), .signals_i(sig2),
    .tx_o(tx2), .busy_o(busy2), .full_o(full2), .count_o(count2), .overflow_o(ovf2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];
  int         wpos       = -1;
  logic [7:0] m_cur      = '0;
  logic       m_ovf      = 1'b0;
  logic       m_prev_hit = 1'b0;
  int         cyc        = 0;
  bit         chk_en     = 1'b0;

  // Line level during frame bit k of byte b.
  function automatic logic frame_level(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef IO_UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic m_tx();
    if (wpos < 0) return 1'b1;
    return frame_level(m_cur, wpos / CPB);
  endfunction

  // One clock edge: reset, frame playback / pop, then edge-triggered push.
  task automatic model_step();
    logic hit, push, idle_pop;
    hit = signals_i[2] && (addr_i == 16'h0004);
    if (rst) begin
      mq.delete();
      wpos       = -1;
      m_ovf      = 1'b0;
      m_prev_hit = 1'b0;
      return;
    end
    push       = hit && !m_prev_hit;
    m_prev_hit = hit;
    idle_pop   = (wpos < 0) && (mq.size() > 0);
    if (wpos >= 0) begin
      wpos++;
      if (wpos == FRAME_LEN) wpos = -1;
    end else if (idle_pop) begin
      m_cur = mq.pop_front();
      wpos  = 0;
    end
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(data_i[7:0]);
      else m_ovf = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
    if (rst) chk_en = 1'b1;
  end

  // Per-cycle comparison of every output of the fast instance.
  initial forever begin
    logic [8:0] exp_v;
    @(negedge clk);
    if (chk_en) begin
      exp_v = {m_tx(), (wpos >= 0), (mq.size() == DEPTH), m_ovf, 5'(mq.size())};
      chk("model_outputs", {23'd0, tx_o, busy_o, full_o, overflow_o, count_o}, {23'd0, exp_v});
    end
  end

  // ---------------- serial receiver (fast instance) ----------------
  bit         rx_en = 1'b0;
  logic [7:0] rx_q[$];

  initial forever begin
    logic [7:0] rb;
    @(negedge clk);
    if (rx_en && (tx_o === 1'b0)) begin
      repeat (CPB / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        rb[k] = tx_o;
      end
      repeat (CPB * (FRAME_BITS - 9)) @(negedge clk);
      rx_q.push_back(rb);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic wv[64];
  logic bv[64];

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wv[i] = tx_o;
      bv[i] = busy_o;
    end
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d, input logic [2:0] s, input int n);
    addr_i    = a;
    data_i    = d;
    signals_i = s;
    repeat (n) @(negedge clk);
    signals_i = 3'b000;
  endtask

  initial begin
    int         bad, peak, starts, busy_n, lows, mark;
    logic       prev_busy;
    logic [10:0] expf;
    logic [9:0] exps;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_ovf", overflow_o, 0);
    rst = 1'b0;

    // Idle for 100 cycles.
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || count_o !== 5'd0 || overflow_o !== 1'b0) bad++;
      if (tx2 !== 1'b1 || busy2 !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Default-rate instance: fill to full, overflow, then first frame timing.
    addr2 = 16'h0004; data2 = 16'h0000; sig2 = 3'b100;
    @(negedge clk);
    sig2 = 3'b000;
    chk("slow_count_after_push", count2, 1);
    @(negedge clk);
    chk("slow_start_low", tx2, 0);
    mark = cyc;
    for (int k = 1; k <= 16; k++) begin
      data2 = 16'(k); sig2 = 3'b100;
      @(negedge clk);
      sig2 = 3'b000;
      @(negedge clk);
    end
    chk("slow_full", full2, 1);
    chk("slow_count16", count2, 16);
    chk("slow_no_ovf_yet", ovf2, 0);
    data2 = 16'h0011; sig2 = 3'b100;
    @(negedge clk);
    sig2 = 3'b000;
    chk("slow_ovf", ovf2, 1);
    chk("slow_count_kept", count2, 16);
    exps = 10'b1000000000;
    for (int b = 0; b < 10; b++) begin
      while (cyc < mark + SLOW_CPB * b + SLOW_CPB / 2) @(negedge clk);
      chk("slow_frame0_bit", tx2, exps[b]);
    end
    while (cyc < mark + 10 * SLOW_CPB) @(negedge clk);
    chk("slow_gap_tx", tx2, 1);
    chk("slow_gap_busy", busy2, 0);
    @(negedge clk);
    chk("slow_next_start", tx2, 0);
    chk("slow_count15", count2, 15);

    // Single store of 0x55.
    store(16'h0004, 16'h1255, 3'b100, 1);
    chk("single_count1", count_o, 1);
    chk("single_tx_pre", tx_o, 1);
    capture(48);
`ifdef IO_UART_TX_PARITY_EN
    expf = 11'b10010101010;
    lows = 24;
`else
    expf = 11'b11010101010;
    lows = 20;
`endif
    chk("single_start_2_after", wv[0], 0);
    for (int b = 0; b < FRAME_BITS; b++) chk("single_bit", wv[4 * b + 2], expf[b]);
    busy_n = 0; bad = 0;
    for (int i = 0; i < 48; i++) begin
      busy_n += int'(bv[i]);
      bad    += int'(!wv[i]);
    end
    chk("single_frame_len", busy_n, FRAME_LEN);
    chk("single_low_cycles", bad, lows);

    // Store held for 5 cycles: one push, one frame.
    peak = 0; starts = 0; prev_busy = busy_o;
    addr_i = 16'h0004; data_i = 16'h0041; signals_i = 3'b100;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 4) signals_i = 3'b000;
      if (int'(count_o) > peak) peak = int'(count_o);
      if (busy_o && !prev_busy) starts++;
      prev_busy = busy_o;
    end
    chk("held_peak_count", peak, 1);
    chk("held_frames", starts, 1);

    // Ignored stores.
    store(16'h0008, 16'h00aa, 3'b100, 2);
    chk("other_addr_count", count_o, 0);
    store(16'h0004, 16'h00bb, 3'b010, 2);
    chk("regwrite_count", count_o, 0);
    store(16'h0004, 16'h00cc, 3'b011, 2);
    repeat (3) @(negedge clk);
    chk("ignored_count", count_o, 0);
    chk("ignored_tx", tx_o, 1);
    chk("ignored_busy", busy_o, 0);

    // Fill 17 bytes, overflow, drain in order.
    rx_en = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      store(16'h0004, 16'(k), 3'b100, 1);
      @(negedge clk);
    end
    chk("fill_full", full_o, 1);
    chk("fill_count16", count_o, 16);
    chk("fill_no_ovf", overflow_o, 0);
    store(16'h0004, 16'h00aa, 3'b100, 1);
    chk("fill_ovf", overflow_o, 1);
    chk("fill_count_kept", count_o, 16);
    for (int i = 0; i < 1500 && !(count_o == 5'd0 && busy_o == 1'b0); i++) @(negedge clk);
    chk("drain_done", {count_o, busy_o}, 6'd0);
    repeat (4) @(negedge clk);
    rx_en = 1'b0;
    chk("rx_count", rx_q.size(), 17);
    for (int i = 0; i < rx_q.size() && i < 17; i++) chk("rx_byte", rx_q[i], i);
    chk("ovf_sticky", overflow_o, 1);

    // Reset mid-DATA with 3 bytes queued.
    for (int k = 0; k < 4; k++) begin
      store(16'h0004, 16'h0000, 3'b100, 1);
      @(negedge clk);
    end
    chk("midrst_count3", count_o, 3);
    chk("midrst_busy", busy_o, 1);
    chk("midrst_tx_low", tx_o, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", tx_o, 1);
    chk("midrst_count0", count_o, 0);
    chk("midrst_busy0", busy_o, 0);
    chk("midrst_ovf0", overflow_o, 0);
    rst = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    chk("after_rst_quiet", bad, 0);

    // Byte 0x07: parity bit is 1 when enabled.
    store(16'h0004, 16'h0007, 3'b100, 1);
    capture(50);
    busy_n = 0;
    for (int i = 0; i < 50; i++) busy_n += int'(bv[i]);
    chk("b07_frame_len", busy_n, FRAME_LEN);
    chk("b07_bit9", wv[4 * 9 + 2], 1);
    chk("b07_bit3", wv[4 * 3 + 2], 1);
    chk("b07_bit4", wv[4 * 4 + 2], 0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
